branch_predictor_btb: RTL and testbench

//  Parametrised dynamic branch predictor: direct-mapped BTB plus per-entry saturating direction counters.

---
 rtl/branch_predictor_btb_if.sv | 37 +++
 rtl/branch_predictor_btb.sv | 132 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup, execute-resolve and statistics signals between the pipeline and the BTB predictor.
// slave is the predictor side, master the pipeline (or bench) side.
interface branch_predictor_btb_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_pc_F;
    logic             o_pred_taken_F;
    logic [31:0]      o_pred_target_F;

    logic             i_upd_vld;
    logic [31:0]      i_upd_pc;
    logic             i_upd_is_ctrl;
    logic             i_upd_is_jump;
    logic             i_upd_taken;
    logic [31:0]      i_upd_target;
    logic             i_upd_pred_taken;
    logic [31:0]      i_upd_pred_target;
    logic             o_mispred_E;
    logic [31:0]      o_redirect_pc_E;

    logic [CNT_W-1:0] o_ctrl_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport slave (
        input  i_pc_F, i_upd_vld, i_upd_pc, i_upd_is_ctrl, i_upd_is_jump, i_upd_taken,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        output o_pred_taken_F, o_pred_target_F, o_mispred_E, o_redirect_pc_E,
               o_ctrl_cnt, o_mispred_cnt
    );

    modport master (
        output i_pc_F, i_upd_vld, i_upd_pc, i_upd_is_ctrl, i_upd_is_jump, i_upd_taken,
               i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        input  o_pred_taken_F, o_pred_target_F, o_mispred_E, o_redirect_pc_E,
               o_ctrl_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters; zero-latency fetch lookup,
// execute-stage training, mispredict/redirect generation and saturating statistics.
module branch_predictor_btb #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

    logic             valid_q [ENTRIES];
    logic             jump_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [30:0]      tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] idx_f, idx_u;
    logic [TAG_W-1:0] tag_f, tag_u;
    logic             hit_f, hit_u;
    logic             pred_taken_f;
    logic             actual_taken;
    logic             mispred;

    logic             wr_en;
    logic             valid_d;
    logic             jump_d;
    logic [TAG_W-1:0] tag_d;
    logic [30:0]      tgt_d;
    logic [CTR_W-1:0] ctr_d;

    // Bit 0 of targets is architecturally zero and never stored or compared.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^{bus.i_upd_target[0], bus.i_upd_pred_target[0]};

    assign idx_f = bus.i_pc_F[IDX_W+1:2];
    assign tag_f = bus.i_pc_F[IDX_W+2 +: TAG_W];
    assign idx_u = bus.i_upd_pc[IDX_W+1:2];
    assign tag_u = bus.i_upd_pc[IDX_W+2 +: TAG_W];

    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_u        = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    assign pred_taken_f = hit_f && (jump_q[idx_f] || ctr_q[idx_f][CTR_W-1]);

    assign bus.o_pred_taken_F  = pred_taken_f;
    assign bus.o_pred_target_F = pred_taken_f ? {tgt_q[idx_f], 1'b0} : bus.i_pc_F + 32'd4;

    assign actual_taken = bus.i_upd_is_ctrl && bus.i_upd_taken;
    assign mispred = bus.i_upd_vld &&
                     ((actual_taken != bus.i_upd_pred_taken) ||
                      (actual_taken && bus.i_upd_pred_taken &&
                       (bus.i_upd_target[31:1] != bus.i_upd_pred_target[31:1])));

    assign bus.o_mispred_E     = mispred;
    assign bus.o_redirect_pc_E = actual_taken ? {bus.i_upd_target[31:1], 1'b0}
                                              : bus.i_upd_pc + 32'd4;

    assign bus.o_ctrl_cnt    = ctrl_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;

    always_comb begin
        wr_en   = 1'b0;
        valid_d = valid_q[idx_u];
        jump_d  = jump_q[idx_u];
        tag_d   = tag_q[idx_u];
        tgt_d   = tgt_q[idx_u];
        ctr_d   = ctr_q[idx_u];
        if (bus.i_upd_vld) begin
            if (bus.i_upd_is_ctrl) begin
                if (hit_u) begin
                    wr_en  = 1'b1;
                    jump_d = bus.i_upd_is_jump;
                    if (bus.i_upd_taken) begin
                        tgt_d = bus.i_upd_target[31:1];
                        if (ctr_q[idx_u] != '1) ctr_d = ctr_q[idx_u] + CTR_W'(1);
                    end else if (ctr_q[idx_u] != '0) begin
                        ctr_d = ctr_q[idx_u] - CTR_W'(1);
                    end
                end else if (bus.i_upd_taken) begin
                    wr_en   = 1'b1;
                    valid_d = 1'b1;
                    jump_d  = bus.i_upd_is_jump;
                    tag_d   = tag_u;
                    tgt_d   = bus.i_upd_target[31:1];
                    ctr_d   = CTR_WEAK_T;
                end
            end else if (hit_u) begin
                // A non-control instruction hitting the table is a stale alias.
                wr_en   = 1'b1;
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_cnt_d    = ctrl_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.i_upd_vld && bus.i_upd_is_ctrl && (ctrl_cnt_q != '1))
            ctrl_cnt_d = ctrl_cnt_q + CNT_W'(1);
        if (mispred && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[idx_u] <= valid_d;
                jump_q[idx_u]  <= jump_d;
                tag_q[idx_u]   <= tag_d;
                tgt_q[idx_u]   <= tgt_d;
                ctr_q[idx_u]   <= ctr_d;
            end
            ctrl_cnt_q    <= ctrl_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: directed scenarios plus randomized traffic against
// a behavioural table model; a negedge monitor pops and compares the expected responses.
module tb_branch_predictor_btb;
    localparam int ENTRIES = 8;
    localparam int TAG_W   = 2;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 5;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_btb_if #(.CNT_W(CNT_W)) bus ();

    branch_predictor_btb #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    bit          m_valid [ENTRIES];
    bit          m_jump  [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_ctrl_cnt;
    int          m_mis_cnt;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] rpc;
        int          cc;
        int          mc;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    // Taken when the entry is a jump or its counter sits in the upper half of its range.
    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_jump[m_idx(pc)] || (m_ctr[m_idx(pc)] >= (1 << (CTR_W - 1))));
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = (1 << (CTR_W - 1)) - 1;
        end
        m_ctrl_cnt = 0;
        m_mis_cnt  = 0;
    endfunction

    task automatic step(input bit r, input logic [31:0] pcf, input bit vld, input logic [31:0] upc,
                        input bit ctrl, input bit jmp, input bit tkn, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptg);
        exp_t e;
        bit   act;
        bit   hit;
        int   i;
        @(posedge clk);
        #1;
        rst                   = r;
        bus.i_pc_F            = pcf;
        bus.i_upd_vld         = vld;
        bus.i_upd_pc          = upc;
        bus.i_upd_is_ctrl     = ctrl;
        bus.i_upd_is_jump     = jmp;
        bus.i_upd_taken       = tkn;
        bus.i_upd_target      = tgt;
        bus.i_upd_pred_taken  = ptk;
        bus.i_upd_pred_target = ptg;

        act    = ctrl && tkn;
        e.pt   = m_pred_taken(pcf);
        e.ptgt = m_pred_target(pcf);
        e.mp   = vld && ((act != ptk) || (act && (tgt[31:1] != ptg[31:1])));
        e.rpc  = act ? {tgt[31:1], 1'b0} : upc + 32'd4;
        e.cc   = m_ctrl_cnt;
        e.mc   = m_mis_cnt;
        sb_q.push_back(e);

        if (r) begin
            m_clear();
        end else begin
            if (vld && ctrl && m_ctrl_cnt < CNT_MAX) m_ctrl_cnt++;
            if (e.mp && m_mis_cnt < CNT_MAX) m_mis_cnt++;
            if (vld) begin
                i   = m_idx(upc);
                hit = m_hit(upc);
                if (ctrl && hit) begin
                    m_jump[i] = jmp;
                    if (tkn) begin
                        m_tgt[i] = {tgt[31:1], 1'b0};
                        m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (ctrl && tkn) begin
                    m_valid[i] = 1'b1;
                    m_jump[i]  = jmp;
                    m_tag[i]   = m_tagof(upc);
                    m_tgt[i]   = {tgt[31:1], 1'b0};
                    m_ctr[i]   = 1 << (CTR_W - 1);
                end else if (!ctrl && hit) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(1'b0, pcf, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic rand_step();
        logic [31:0] pcf, upc, tgt, ptg;
        bit          r, vld, ctrl, jmp, tkn, ptk;
        pcf  = 32'($urandom_range(0, 63)) << 2;
        upc  = 32'($urandom_range(0, 63)) << 2;
        vld  = ($urandom_range(0, 9) != 0);
        ctrl = ($urandom_range(0, 3) != 0);
        jmp  = ctrl && ($urandom_range(0, 3) == 0);
        tkn  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
        tgt  = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            ptk = m_pred_taken(upc);
            ptg = m_pred_target(upc);
        end else begin
            ptk = 1'($urandom_range(0, 1));
            ptg = ($urandom_range(0, 1) != 0) ? (tgt ^ 32'($urandom_range(0, 1))) : $urandom;
        end
        r = ($urandom_range(0, 99) == 0);
        step(r, pcf, vld, upc, ctrl, jmp, tkn, tgt, ptk, ptg);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_pred_taken",  32'(bus.o_pred_taken_F), 32'(e.pt));
            chk("sb_pred_target", bus.o_pred_target_F,     e.ptgt);
            chk("sb_mispred",     32'(bus.o_mispred_E),    32'(e.mp));
            chk("sb_redirect",    bus.o_redirect_pc_E,     e.rpc);
            chk("sb_ctrl_cnt",    32'(bus.o_ctrl_cnt),     32'(e.cc));
            chk("sb_mispred_cnt", 32'(bus.o_mispred_cnt),  32'(e.mc));
        end
    end

    initial begin
        bus.i_pc_F            = 32'd0;
        bus.i_upd_vld         = 1'b0;
        bus.i_upd_pc          = 32'd0;
        bus.i_upd_is_ctrl     = 1'b0;
        bus.i_upd_is_jump     = 1'b0;
        bus.i_upd_taken       = 1'b0;
        bus.i_upd_target      = 32'd0;
        bus.i_upd_pred_taken  = 1'b0;
        bus.i_upd_pred_target = 32'd0;
        rst = 1'b1;
        m_clear();
        repeat (3) @(posedge clk);

        // Reset state
        idle(32'h100);
        #1;
        chk("rst_pred_taken",  32'(bus.o_pred_taken_F), 32'd0);
        chk("rst_pred_target", bus.o_pred_target_F,     32'h104);
        chk("rst_ctrl_cnt",    32'(bus.o_ctrl_cnt),     32'd0);
        chk("rst_mispred_cnt", 32'(bus.o_mispred_cnt),  32'd0);

        // Taken branch allocates with a weak-taken counter
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        chk("alloc_mispred",  32'(bus.o_mispred_E), 32'd1);
        chk("alloc_redirect", bus.o_redirect_pc_E,  32'h80);
        idle(32'h100);
        #1;
        chk("alloc_pred_taken",  32'(bus.o_pred_taken_F), 32'd1);
        chk("alloc_pred_target", bus.o_pred_target_F,     32'h80);

        // Counter saturates at the top, then two not-taken resolutions flip the prediction
        repeat (3) step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(32'h100);
        #1;
        chk("sat_still_taken", 32'(bus.o_pred_taken_F), 32'd1);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(32'h100);
        #1;
        chk("flip_not_taken",  32'(bus.o_pred_taken_F), 32'd0);
        chk("flip_target",     bus.o_pred_target_F,     32'h104);
        chk("dir_ctrl_cnt",    32'(bus.o_ctrl_cnt),     32'd6);
        chk("dir_mispred_cnt", 32'(bus.o_mispred_cnt),  32'd3);

        // JAL allocation, then JALR retarget
        step(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        idle(32'h200);
        #1;
        chk("jal_pred_taken",  32'(bus.o_pred_taken_F), 32'd1);
        chk("jal_pred_target", bus.o_pred_target_F,     32'h400);
        step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400);
        #1;
        chk("jalr_mispred",  32'(bus.o_mispred_E), 32'd1);
        chk("jalr_redirect", bus.o_redirect_pc_E,  32'h500);
        idle(32'h200);
        #1;
        chk("jalr_new_target", bus.o_pred_target_F, 32'h500);

        // Same index, different tag: a non-ctrl miss must not disturb the entry
        step(1'b0, 32'h220, 1'b1, 32'h220, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h224);
        #1;
        chk("tagmiss_lookup", 32'(bus.o_pred_taken_F), 32'd0);
        idle(32'h200);
        #1;
        chk("tagmiss_kept", 32'(bus.o_pred_taken_F), 32'd1);

        // Non-ctrl hit invalidates the aliased entry
        step(1'b0, 32'h200, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        #1;
        chk("alias_mispred",  32'(bus.o_mispred_E), 32'd1);
        chk("alias_redirect", bus.o_redirect_pc_E,  32'h204);
        idle(32'h200);
        #1;
        chk("alias_invalidated", 32'(bus.o_pred_taken_F), 32'd0);

        // Statistics saturation, then reset with an update presented
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (40) step(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h304);
        idle(32'h300);
        #1;
        chk("satcnt_mispred", 32'(bus.o_mispred_cnt), 32'(CNT_MAX));
        chk("satcnt_ctrl",    32'(bus.o_ctrl_cnt),    32'(CNT_MAX));
        step(1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0, 32'h108);
        idle(32'h104);
        #1;
        chk("midrst_no_update",  32'(bus.o_pred_taken_F), 32'd0);
        chk("midrst_target",     bus.o_pred_target_F,     32'h108);
        chk("midrst_ctrl_cnt",   32'(bus.o_ctrl_cnt),     32'd0);
        chk("midrst_mispred_cnt", 32'(bus.o_mispred_cnt), 32'd0);
        idle(32'h300);
        #1;
        chk("midrst_cleared", 32'(bus.o_pred_taken_F), 32'd0);

        // Randomized traffic in bursts
        for (int b = 0; b < 6; b++) begin
            step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            for (int k = 0; k < 80; k++) rand_step();
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
